// File: rtl/bcd_counter_seg_mux.sv
// bcd_counter_seg_mux
//   N-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
//   Count and scan rates come from clock-enable prescalers; no clocks are derived.
// Ports
//   CLK       system clock, all logic on posedge
//   RESET     synchronous, active-high
//   EN        count enable, gates the count prescaler
//   UP_DN     1 = count up, 0 = count down
//   LOAD      load LOAD_VAL this cycle (nibbles >9 clamp to 9)
//   LOAD_VAL  BCD load value, digit 0 in [3:0]
//   BLANK_LZ  1 = blank leading zeros
//   COUNT_BCD current count, registered
//   CARRY     one-cycle pulse on wrap in either direction
//   SEG_C     segments {g,f,e,d,c,b,a}, registered
//   SEG_SEL   digit select, bit i = digit i, registered
module bcd_counter_seg_mux #(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned COUNT_DIV      = 10_000_000,
  parameter int unsigned SCAN_DIV       = 50_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    UP_DN,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
  input  logic                    BLANK_LZ,
  output logic [4*NUM_DIGITS-1:0] COUNT_BCD,
  output logic                    CARRY,
  output logic [6:0]              SEG_C,
  output logic [7:0]              SEG_SEL
);

  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(COUNT_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] SEL_OFF = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

  // BCD digit to active-high segment pattern gfedcba
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_pre;
  logic [SW-1:0] scan_pre;
  logic [IW-1:0] scan_idx;
  logic          tick_c;
  logic          scan_step_c;
  logic [BW-1:0] next_bcd_c;
  logic          wrap_c;
  logic [BW-1:0] load_clamp_c;
  logic [6:0]    seg_nxt_c;
  logic [7:0]    sel_nxt_c;

  assign tick_c      = EN && (cnt_pre == CW'(COUNT_DIV - 1));
  assign scan_step_c = (scan_pre == SW'(SCAN_DIV - 1));

  // Count prescaler: holds while EN=0, cleared by LOAD
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_pre <= '0;
    end else if (LOAD) begin
      cnt_pre <= '0;
    end else if (EN) begin
      cnt_pre <= tick_c ? '0 : cnt_pre + CW'(1);
    end
  end

  // Ripple next count: a digit steps only while every lower digit sits at its terminal value
  always_comb begin
    logic       all_term;
    logic [3:0] d;
    next_bcd_c = COUNT_BCD;
    all_term   = 1'b1;
    d          = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      d = COUNT_BCD[4*i +: 4];
      if (all_term) begin
        if (UP_DN) next_bcd_c[4*i +: 4] = (d >= 4'd9) ? 4'd0 : d + 4'd1;
        else       next_bcd_c[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      end
      all_term = all_term & (UP_DN ? (d == 4'd9) : (d == 4'd0));
    end
    wrap_c = all_term;
  end

  // Load value with out-of-range nibbles clamped to 9
  always_comb begin
    load_clamp_c = LOAD_VAL;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (LOAD_VAL[4*i +: 4] > 4'd9) load_clamp_c[4*i +: 4] = 4'd9;
    end
  end

  // Counter and carry: RESET > LOAD > tick
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT_BCD <= '0;
      CARRY     <= 1'b0;
    end else if (LOAD) begin
      COUNT_BCD <= load_clamp_c;
      CARRY     <= 1'b0;
    end else if (tick_c) begin
      COUNT_BCD <= next_bcd_c;
      CARRY     <= wrap_c;
    end else begin
      CARRY     <= 1'b0;
    end
  end

  // Free-running scan prescaler and digit index
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_pre <= '0;
      scan_idx <= '0;
    end else if (scan_step_c) begin
      scan_pre <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_pre <= scan_pre + SW'(1);
    end
  end

  // Display decode for the currently scanned digit, including leading-zero blanking
  always_comb begin
    logic [3:0]            cur;
    logic [NUM_DIGITS-1:0] lz;
    logic                  hi_zero;
    logic [7:0]            sel_raw;
    logic                  blank;
    cur     = 4'd0;
    lz      = '0;
    hi_zero = 1'b1;
    sel_raw = 8'h00;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (COUNT_BCD[4*i +: 4] == 4'd0);
      lz[i]   = hi_zero;
    end
    blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scan_idx == IW'(i)) begin
        cur        = COUNT_BCD[4*i +: 4];
        sel_raw[i] = 1'b1;
        blank      = BLANK_LZ && (i != 0) && lz[i];
      end
    end
    seg_nxt_c = blank ? 7'h00 : seg_decode(cur);
    if (SEG_ACTIVE_LOW) seg_nxt_c = ~seg_nxt_c;
    sel_nxt_c = SEL_ACTIVE_LOW ? ~sel_raw : sel_raw;
  end

  // Display output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_C   <= SEG_OFF;
      SEG_SEL <= SEL_OFF;
    end else begin
      SEG_C   <= seg_nxt_c;
      SEG_SEL <= sel_nxt_c;
    end
  end

endmodule

// File: tb/tb_bcd_counter_seg_mux.sv
// Self-checking bench for bcd_counter_seg_mux (3 digits, COUNT_DIV=4, SCAN_DIV=2).
module tb_bcd_counter_seg_mux;

  localparam int unsigned ND = 3;

  logic          CLK = 1'b0;
  logic          RESET, EN, UP_DN, LOAD, BLANK_LZ;
  logic [11:0]   LOAD_VAL;
  logic [11:0]   COUNT_BCD;
  logic          CARRY;
  logic [6:0]    SEG_C;
  logic [7:0]    SEG_SEL;

  always #5 CLK = ~CLK;

  bcd_counter_seg_mux #(
    .NUM_DIGITS(ND), .COUNT_DIV(4), .SCAN_DIV(2),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .UP_DN(UP_DN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .BLANK_LZ(BLANK_LZ), .COUNT_BCD(COUNT_BCD),
    .CARRY(CARRY), .SEG_C(SEG_C), .SEG_SEL(SEG_SEL)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] count;
    logic        carry;
    logic [7:0]  sel;
    logic [6:0]  seg;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: count held as a plain decimal integer
  int         m_val, m_pre, m_spre, m_idx;
  logic       m_carry;
  logic [7:0] m_sel;
  logic [6:0] m_seg;
  logic [6:0] seg_lut [0:9];

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    for (int k = 0; k < 3; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [11:0] b);
    int s = 0;
    int n;
    for (int k = 0; k < 3; k++) begin
      n = int'(b[4*k +: 4]);
      if (n > 9) n = 9;
      s = s + n * pow10(k);
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance model one edge from current inputs, push expectation, clock DUT, pop and compare
  task automatic step();
    exp_t e;
    int   p, dig;
    logic tick;
    if (RESET) begin
      m_val = 0; m_carry = 1'b0; m_pre = 0; m_spre = 0; m_idx = 0;
      m_seg = 7'h00; m_sel = 8'hFF;
    end else begin
      p     = pow10(m_idx);
      dig   = (m_val / p) % 10;
      m_seg = (BLANK_LZ && m_idx > 0 && m_val < p) ? 7'h00 : seg_lut[dig];
      m_sel = ~(8'h01 << m_idx);
      tick  = EN && (m_pre == 3);
      if (m_spre == 1) begin
        m_spre = 0;
        m_idx  = (m_idx + 1) % ND;
      end else begin
        m_spre = m_spre + 1;
      end
      if (LOAD) begin
        m_val = from_bcd_clamped(LOAD_VAL); m_pre = 0; m_carry = 1'b0;
      end else begin
        if (EN) m_pre = tick ? 0 : m_pre + 1;
        m_carry = 1'b0;
        if (tick) begin
          if (UP_DN) begin
            m_carry = (m_val == 999);
            m_val   = (m_val + 1) % 1000;
          end else begin
            m_carry = (m_val == 0);
            m_val   = (m_val == 0) ? 999 : m_val - 1;
          end
        end
      end
    end
    e.count = to_bcd(m_val); e.carry = m_carry; e.sel = m_sel; e.seg = m_seg;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("sb_count", 32'(COUNT_BCD), 32'(e.count));
    chk("sb_carry", 32'(CARRY),     32'(e.carry));
    chk("sb_sel",   32'(SEG_SEL),   32'(e.sel));
    chk("sb_seg",   32'(SEG_C),     32'(e.seg));
  endtask

  task automatic do_load(input logic [11:0] v);
    LOAD = 1'b1; LOAD_VAL = v;
    step();
    LOAD = 1'b0;
  endtask

  typedef struct {
    logic [11:0] load_val;
    logic        blz;
    logic [11:0] exp_count;
    logic [6:0]  exp_seg [0:2];
  } vec_t;
  vec_t vecs [0:6];

  initial begin
    bit seen [0:2];
    int guard;
    seg_lut[0] = 7'h3F; seg_lut[1] = 7'h06; seg_lut[2] = 7'h5B; seg_lut[3] = 7'h4F;
    seg_lut[4] = 7'h66; seg_lut[5] = 7'h6D; seg_lut[6] = 7'h7D; seg_lut[7] = 7'h07;
    seg_lut[8] = 7'h7F; seg_lut[9] = 7'h6F;

    vecs[0] = '{12'h007, 1'b1, 12'h007, '{7'h07, 7'h00, 7'h00}};
    vecs[1] = '{12'h007, 1'b0, 12'h007, '{7'h07, 7'h3F, 7'h3F}};
    vecs[2] = '{12'h1FA, 1'b1, 12'h199, '{7'h6F, 7'h6F, 7'h06}};
    vecs[3] = '{12'h050, 1'b1, 12'h050, '{7'h3F, 7'h6D, 7'h00}};
    vecs[4] = '{12'h000, 1'b1, 12'h000, '{7'h3F, 7'h00, 7'h00}};
    vecs[5] = '{12'h803, 1'b1, 12'h803, '{7'h4F, 7'h3F, 7'h7F}};
    vecs[6] = '{12'h246, 1'b0, 12'h246, '{7'h7D, 7'h66, 7'h5B}};

    RESET = 1'b1; EN = 1'b0; UP_DN = 1'b1; LOAD = 1'b0; LOAD_VAL = '0; BLANK_LZ = 1'b0;
    step();
    step();
    RESET = 1'b0;

    // 1: count to 005 then reset
    EN = 1'b1;
    guard = 0;
    while (COUNT_BCD !== 12'h005 && guard < 100) begin step(); guard++; end
    chk("reach_005", 32'(COUNT_BCD), 32'h005);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_count", 32'(COUNT_BCD), 32'h000);
    chk("rst_sel",   32'(SEG_SEL),   32'hFF);
    chk("rst_seg",   32'(SEG_C),     32'h00);
    chk("rst_carry", 32'(CARRY),     32'h0);

    // 2: up wrap 998 -> 999 -> 000 with single carry
    do_load(12'h998);
    for (int k = 0; k < 3; k++) step();
    chk("up_hold_998", 32'(COUNT_BCD), 32'h998);
    step();
    chk("up_999", 32'(COUNT_BCD), 32'h999);
    chk("up_999_nocarry", 32'(CARRY), 32'h0);
    for (int k = 0; k < 4; k++) step();
    chk("up_wrap_000", 32'(COUNT_BCD), 32'h000);
    chk("up_wrap_carry", 32'(CARRY), 32'h1);
    step();
    chk("up_carry_drop", 32'(CARRY), 32'h0);
    do_load(12'h099);
    for (int k = 0; k < 4; k++) step();
    chk("up_099_100", 32'(COUNT_BCD), 32'h100);

    // 3: down wrap 000 -> 999, then 100 -> 099
    UP_DN = 1'b0;
    do_load(12'h000);
    for (int k = 0; k < 4; k++) step();
    chk("dn_wrap_999", 32'(COUNT_BCD), 32'h999);
    chk("dn_wrap_carry", 32'(CARRY), 32'h1);
    do_load(12'h100);
    for (int k = 0; k < 4; k++) step();
    chk("dn_100_099", 32'(COUNT_BCD), 32'h099);

    // 4: load coincident with a tick, clamped, next tick four cycles later
    UP_DN = 1'b1;
    guard = 0;
    while (m_pre != 3 && guard < 10) begin step(); guard++; end
    do_load(12'h1FA);
    chk("load_clamp", 32'(COUNT_BCD), 32'h199);
    for (int k = 0; k < 3; k++) step();
    chk("load_tick_discard", 32'(COUNT_BCD), 32'h199);
    step();
    chk("load_next_tick", 32'(COUNT_BCD), 32'h200);

    // 5: EN low freezes count while scan keeps running
    EN = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("en_hold", 32'(COUNT_BCD), 32'h200);

    // 6: display vectors, including leading-zero blanking
    for (int v = 0; v < 7; v++) begin
      BLANK_LZ = vecs[v].blz;
      do_load(vecs[v].load_val);
      chk("vec_count", 32'(COUNT_BCD), 32'(vecs[v].exp_count));
      seen = '{default: 1'b0};
      for (int k = 0; k < 8; k++) begin
        step();
        if (k >= 1) begin
          for (int d = 0; d < 3; d++) begin
            if (SEG_SEL == ~(8'h01 << d)) begin
              seen[d] = 1'b1;
              chk($sformatf("vec%0d_dig%0d", v, d), 32'(SEG_C), 32'(vecs[v].exp_seg[d]));
            end
          end
        end
      end
      for (int d = 0; d < 3; d++) chk($sformatf("vec%0d_seen%0d", v, d), 32'(seen[d]), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
